// File: rtl/uart_rx_deframer.sv
// 8N1 receive deframer for a 16x-oversampled serial line.
// Recovers bytes LSB-first and reports each frame as a good byte or a framing error.
module uart_rx_deframer #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int SAMP_PER_BIT = 16,
   parameter int BAUD_RATE    = 9600,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 sig_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic                 frame_err_out,
   output logic                 busy_out
);

   localparam int DIV = CLK_HZ / (SAMP_PER_BIT * BAUD_RATE);
   localparam int SW  = $clog2(SAMP_PER_BIT);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam logic [15:0]   TICK_RELOAD = 16'(DIV - 1);
   localparam logic [SW-1:0] HALF_M1     = SW'(SAMP_PER_BIT / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST   = SW'(SAMP_PER_BIT - 1);
   localparam logic [BW-1:0] BITS_ALL    = BW'(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            tick_cnt_q, tick_cnt_d;
   logic [SW-1:0]          samp_q, samp_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   tick;
   logic [SW-1:0]          samp_inc;
   logic [BW-1:0]          bit_inc;

   // Free-running prescaler; line activity never re-phases it.
   assign tick       = (tick_cnt_q == 16'd0);
   assign tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - 16'd1;
   assign samp_inc   = samp_q + 1'b1;
   assign bit_inc    = bit_q + 1'b1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         tick_cnt_q <= TICK_RELOAD;
         samp_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!sig_in) begin
                  state_d = START;
                  samp_d  = '0;
               end
            end
            START: begin
               samp_d = samp_inc;
               // Decide on the tick where the counter reaches mid start bit.
               if (samp_inc == HALF_M1) begin
                  samp_d  = '0;
                  bit_d   = '0;
                  state_d = sig_in ? IDLE : DATA;
               end
            end
            DATA: begin
               samp_d = samp_inc;
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  shift_d = {sig_in, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_inc;
                  if (bit_inc == BITS_ALL) state_d = STOP;
               end
            end
            STOP: begin
               samp_d = samp_inc;
               if (samp_q == SAMP_LAST) begin
                  samp_d = '0;
                  data_d = shift_q;
                  if (sig_in) begin
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               if (sig_in) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // valid_out/frame_err_out: mutually exclusive single-cycle strobes, no
   // backpressure; data_out stays put until the next frame completes.
   always_comb begin
      data_out      = data_q;
      valid_out     = valid_q;
      frame_err_out = err_q;
      busy_out      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: table of frames plus hand-built corner sequences,
// with strobes checked against a queue of expected {is_err, data} records.
module tb_uart_rx_deframer;

   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       rst;
   logic       sig;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [8:0] exp_q[$];
   int         strobe_cyc[$];

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   uart_rx_deframer #(
      .CLK_HZ      (1_600_000),
      .SAMP_PER_BIT(16),
      .BAUD_RATE   (10_000),
      .DATA_BITS   (8)
   ) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .sig_in       (sig),
      .data_out     (data),
      .valid_out    (valid),
      .frame_err_out(ferr),
      .busy_out     (busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ferr) check("both_strobes", 32'(1), 32'(0));
         if (valid || ferr) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 32'({valid, ferr}), 32'(0));
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("strobe_kind", 32'(ferr), 32'(e[8]));
               check("strobe_data", 32'(data), 32'(e[7:0]));
            end
         end
      end
   end

   // driver tasks: all input changes land 1 time unit after a posedge
   task automatic drive(input logic v, input int n);
      sig = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic exp_err, input logic [7:0] exp_data);
      exp_q.push_back({exp_err, exp_data});
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(d[i], BIT);
      drive(stop, BIT);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int e;
      int lat;
      int gap;

      vecs[0] = '{d: 8'h01, stop: 1'b1, exp_err: 1'b0, exp_data: 8'h01};
      vecs[1] = '{d: 8'h80, stop: 1'b1, exp_err: 1'b0, exp_data: 8'h80};
      vecs[2] = '{d: 8'hC3, stop: 1'b1, exp_err: 1'b0, exp_data: 8'hC3};
      vecs[3] = '{d: 8'h5A, stop: 1'b0, exp_err: 1'b1, exp_data: 8'h5A};
      vecs[4] = '{d: 8'hFE, stop: 1'b1, exp_err: 1'b0, exp_data: 8'hFE};
      for (int i = 5; i < 8; i++) begin
         logic [7:0] r;
         r = 8'($urandom_range(0, 255));
         vecs[i] = '{d: r, stop: 1'(i != 6), exp_err: 1'(i == 6), exp_data: r};
      end

      rst = 1'b1;
      sig = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_valid", 32'(valid), 32'(0));
      check("reset_ferr", 32'(ferr), 32'(0));
      check("reset_data", 32'(data), 32'(0));
      rst = 1'b0;

      // idle line
      drive(1'b1, 2000);
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_data", 32'(data), 32'(0));
      check("idle_strobes", 32'(strobe_cyc.size()), 32'(0));

      // 0xA5 with latency bound from start edge
      n0 = strobe_cyc.size();
      e  = cyc;
      send_frame(8'hA5, 1'b1, 1'b0, 8'hA5);
      drive(1'b1, BIT);
      drain(400);
      check("a5_count", 32'(strobe_cyc.size()), 32'(n0 + 1));
      lat = (strobe_cyc.size() > n0) ? strobe_cyc[n0] - e : 0;
      check("a5_latency_ok", 32'(lat >= 1500 && lat <= 1611), 32'(1));
      check("a5_data_hold", 32'(data), 32'(8'hA5));

      // table of frames
      for (int i = 0; i < 8; i++) begin
         n0 = strobe_cyc.size();
         send_frame(vecs[i].d, vecs[i].stop, vecs[i].exp_err, vecs[i].exp_data);
         drive(1'b1, BIT);
         drain(400);
         check("vec_count", 32'(strobe_cyc.size()), 32'(n0 + 1));
         check("vec_data_hold", 32'(data), 32'(vecs[i].exp_data));
         check("vec_idle_busy", 32'(busy), 32'(0));
      end

      // glitch: 50 cycles low
      n0 = strobe_cyc.size();
      drive(1'b0, 50);
      drive(1'b1, 30);
      check("glitch_busy", 32'(busy), 32'(0));
      drive(1'b1, 400);
      check("glitch_strobes", 32'(strobe_cyc.size()), 32'(n0));

      // framing error followed by a held-low line
      n0 = strobe_cyc.size();
      send_frame(8'h3C, 1'b0, 1'b1, 8'h3C);
      drive(1'b0, 2000);
      check("break_busy", 32'(busy), 32'(1));
      check("break_data", 32'(data), 32'(8'h3C));
      check("break_strobes", 32'(strobe_cyc.size()), 32'(n0 + 1));
      drive(1'b1, 11);
      check("break_release_busy", 32'(busy), 32'(0));
      drain(400);

      // back-to-back frames, no idle gap
      drive(1'b1, BIT);
      n0 = strobe_cyc.size();
      send_frame(8'h00, 1'b1, 1'b0, 8'h00);
      send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
      drive(1'b1, BIT);
      drain(400);
      check("b2b_count", 32'(strobe_cyc.size()), 32'(n0 + 2));
      gap = (strobe_cyc.size() >= n0 + 2) ? strobe_cyc[n0 + 1] - strobe_cyc[n0] : 0;
      check("b2b_spacing_ok", 32'(gap >= 1590 && gap <= 1610), 32'(1));

      // reset during bit 4 of 0x55, then 0x81
      n0 = strobe_cyc.size();
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(1'(i % 2 == 0), BIT);
      drive(1'b1, 80);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_data", 32'(data), 32'(0));
      drive(1'b1, 2 * BIT);
      check("midrst_no_strobe", 32'(strobe_cyc.size()), 32'(n0));
      send_frame(8'h81, 1'b1, 1'b0, 8'h81);
      drive(1'b1, BIT);
      drain(400);
      check("midrst_count", 32'(strobe_cyc.size()), 32'(n0 + 1));
      check("midrst_data_81", 32'(data), 32'(8'h81));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
